// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared constants and types for the iterative multiply/divide unit.
//   WIDTH          : operand width (only 32 is supported)
//   ITER           : number of RUN steps for the iterative paths
//   muldiv_op_t    : MULTU/MULT/DIVU/DIV request encodings
//   muldiv_state_t : IDLE/RUN/FIX sequencer states
// Optional feature macro used by the unit: MULDIV_FAST_MULT_EN
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;

    typedef enum logic [1:0] {
        MULTU = 2'b00,
        MULT  = 2'b01,
        DIVU  = 2'b10,
        DIV   = 2'b11
    } muldiv_op_t;

    // Legacy state encodings, kept as plain constants for drop-in compatibility
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIX  = ST_FIX
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request / result bundle between the ALU control path and muldiv_unit.
//   start, op, a, b     : operation request (master -> slave)
//   hi_we, lo_we, wdata : MTHI/MTLO writes   (master -> slave)
//   busy, done, div_zero: status             (slave -> master)
//   hi, lo              : architectural HI/LO (slave -> master)
// Modports: master (requester), slave (muldiv_unit).
// -----------------------------------------------------------------------------
interface muldiv_if;
    import muldiv_pkg::*;

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_negate.sv
// -----------------------------------------------------------------------------
// muldiv_negate
// Conditional two's-complement negate, purely combinational.
//   W  : data width
//   en : 1 -> y = -x, 0 -> y = x
//   x  : input value
//   y  : output value
// Used for operand magnitudes at start and for result sign correction.
// -----------------------------------------------------------------------------
module muldiv_negate #(
    parameter int unsigned W = 32
) (
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit owning the MIPS HI/LO registers.
//   clk     : clock, all state on rising edge
//   reset_n : synchronous active-low reset
//   bus     : muldiv_if.slave (request, MTHI/MTLO writes, status, HI/LO)
// Operations: MULTU/MULT via 32-step shift-add, DIVU/DIV via 32-step
// restoring divide on operand magnitudes, sign fix-up in FIX.
// Timing: start edge E0, RUN E1..E32, FIX at E33, done in the cycle after E33.
// Optional feature: define MULDIV_FAST_MULT_EN to do MULT/MULTU in a single
// RUN cycle with a combinational 64-bit multiply (FIX at E2).
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = muldiv_pkg::WIDTH
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);

    localparam int unsigned DW = 2 * WIDTH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    muldiv_state_t    state_q,  state_d;
    muldiv_op_t       op_q,     op_d;
    logic [4:0]       cnt_q,    cnt_d;
    // Multiply: {partial product high, multiplier shifting out low}
    // Divide:   {partial remainder, dividend shifting into quotient}
    logic [DW-1:0]    acc_q,    acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide)
    logic [WIDTH-1:0] opnd_q,   opnd_d;
    // Raw dividend, needed for the divide-by-zero HI value
    logic [WIDTH-1:0] a_raw_q,  a_raw_d;
    logic             neg_lo_q, neg_lo_d;   // product / quotient sign
    logic             neg_hi_q, neg_hi_d;   // remainder sign
    logic             bzero_q,  bzero_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             done_q,   done_d;
    logic             dz_q,     dz_d;

    // ------------------------------------------------------------------
    // Operand magnitudes at start (only negated for signed ops)
    // ------------------------------------------------------------------
    logic             req_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign req_signed = bus.op[0];

    muldiv_negate #(.W(WIDTH)) u_neg_a (
        .en (req_signed & bus.a[WIDTH-1]),
        .x  (bus.a),
        .y  (mag_a)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_b (
        .en (req_signed & bus.b[WIDTH-1]),
        .x  (bus.b),
        .y  (mag_b)
    );

    // ------------------------------------------------------------------
    // Result sign correction in FIX
    // ------------------------------------------------------------------
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    muldiv_negate #(.W(DW)) u_neg_prod (
        .en (neg_lo_q),
        .x  (acc_q),
        .y  (prod_fix)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_quo (
        .en (neg_lo_q),
        .x  (acc_q[WIDTH-1:0]),
        .y  (quo_fix)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_rem (
        .en (neg_hi_q),
        .x  (acc_q[DW-1:WIDTH]),
        .y  (rem_fix)
    );

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next;
    logic [WIDTH:0]   div_trial;
    logic [DW-1:0]    div_next;

    always_comb begin
        // Shift-add: conditionally add multiplicand to the high half, then
        // shift the whole accumulator right, carry entering at the top.
        mul_sum  = {1'b0, acc_q[DW-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: trial-subtract the divisor from the remainder
        // shifted left with the next dividend bit. Bit WIDTH of the trial is
        // the borrow, since the shifted remainder is below twice the divisor.
        div_trial = acc_q[DW-1:WIDTH-1] - {1'b0, opnd_q};
        if (!div_trial[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {acc_q[DW-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = muldiv_op_t'(bus.op);
                    cnt_d    = 5'(ITER - 1);
                    a_raw_d  = bus.a;
                    bzero_d  = (bus.b == '0);
                    neg_lo_d = req_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_hi_d = req_signed & bus.a[WIDTH-1];
                    if (bus.op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                    state_d = RUN;
                end else begin
                    if (bus.hi_we) begin
                        hi_d = bus.wdata;
                    end
                    if (bus.lo_we) begin
                        lo_d = bus.wdata;
                    end
                end
            end

            RUN: begin
`ifdef MULDIV_FAST_MULT_EN
                if (!op_is_div(op_q)) begin
                    acc_d   = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
                    state_d = FIX;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = FIX;
                    end
                end
`else
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end
`endif
            end

            FIX: begin
                if (op_is_div(op_q)) begin
                    if (bzero_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[DW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= MULTU;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit with hand-computed results.
// Honours MULDIV_FAST_MULT_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    muldiv_if bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request just after a rising edge, let E0 take it.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen (bounded), and busy samples.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = bus.busy ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int edges;
        int bcnt;
        start_op(op, a, b);
        wait_done(edges, bcnt);
        chk({tag, "_latency"}, 32'(edges), 32'(lat));
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hi"}, bus.hi, exp_hi);
        chk({tag, "_lo"}, bus.lo, exp_lo);
        chk({tag, "_dz"}, 32'(bus.div_zero), 32'(exp_dz));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_dz_pulse"}, 32'(bus.div_zero), 32'd0);
    endtask

    initial begin
        int edges;
        int bcnt;
        int dones;
        n_tests     = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dz", 32'(bus.div_zero), 32'd0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);

        // MULTU max x max, with busy duration
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(edges, bcnt);
        chk("multu_latency", 32'(edges), 32'(MUL_LAT));
        chk("multu_busy_cycles", 32'(bcnt), 32'(MUL_LAT));
        chk("multu_done", 32'(bus.done), 32'd1);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);
        @(posedge clk);
        #1;
        chk("multu_done_pulse", 32'(bus.done), 32'd0);

        // Signed multiply
        run_op("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, MUL_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, MUL_LAT,
               32'h4000_0000, 32'h0000_0000, 1'b0);

        // Signed divide
        run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, DIV_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_neg2", 2'b11, 32'd7, 32'hFFFF_FFFE, DIV_LAT,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min_neg1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
               32'h0000_0000, 32'h8000_0000, 1'b0);

        // Divide by zero then a normal DIVU
        run_op("divu_by0", 2'b10, 32'd100, 32'd0, DIV_LAT,
               32'd100, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, DIV_LAT,
               32'd2, 32'd14, 1'b0);

        // MTHI in idle
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        chk("mthi_lo_kept", bus.lo, 32'd14);

        // MTHI and MTLO together
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5_0F0F;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        chk("mthilo_hi", bus.hi, 32'hA5A5_0F0F);
        chk("mthilo_lo", bus.lo, 32'hA5A5_0F0F);

        // Write strobe together with start is dropped
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0BAD_0BAD;
        start_op(2'b00, 32'd3, 32'd5);
        bus.lo_we = 1'b0;
        chk("we_with_start_lo", bus.lo, 32'hA5A5_0F0F);

        // Disturb inputs while busy: second start, lo_we, operand changes
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        chk("busy_lo_we_dropped", bus.lo, 32'hA5A5_0F0F);
        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'hFFFF_FFFF;
        wait_done(edges, bcnt);
        chk("busy_ops_latency", 32'(edges + 4), 32'(MUL_LAT));
        chk("busy_ops_hi", bus.hi, 32'd0);
        chk("busy_ops_lo", bus.lo, 32'd15);
        @(posedge clk);
        #1;
        chk("no_queued_busy", 32'(bus.busy), 32'd0);

        // Reset during RUN
        start_op(2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);

        // Fresh op after the abandoned one
        run_op("post_rst_multu", 2'b00, 32'd6, 32'd7, MUL_LAT,
               32'd0, 32'd42, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
